// File: rtl/sd_clock_gen.sv
// SD-card clock generator: programmable half-period divider with glitch-free updates,
// enable/flow-control parking of sd_clk low, and registered rise/fall strobes.
module sd_clock_gen #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_stop_req,
  input  logic [DIV_WIDTH-1:0] i_divider,
  output logic                 o_sd_clk,
  output logic                 o_sd_clk_rise,
  output logic                 o_sd_clk_fall,
  output logic                 o_clk_running,
  output logic [DIV_WIDTH-1:0] o_div_active
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_sd_clk;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_running;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_div     <= '0;
      r_sd_clk  <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      unique case (r_state)
        StIdle, StHold: begin
          r_cnt <= '0;
          if (i_enable && !i_stop_req) begin
            r_state   <= StRun;
            r_div     <= i_divider;
            r_running <= 1'b1;
          end else if (!i_enable) begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          if (r_cnt == r_div) begin
            r_cnt    <= '0;
            r_sd_clk <= ~r_sd_clk;
            if (!r_sd_clk) begin
              r_rise <= 1'b1;
            end else begin
              // Only a fall boundary may stop the clock or pick up a new divider.
              r_fall <= 1'b1;
              if (!i_enable) begin
                r_state   <= StIdle;
                r_running <= 1'b0;
              end else if (i_stop_req) begin
                r_state   <= StHold;
                r_running <= 1'b0;
              end else begin
                r_div <= i_divider;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_cnt     <= '0;
          r_sd_clk  <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_sd_clk      = r_sd_clk;
  assign o_sd_clk_rise = r_rise;
  assign o_sd_clk_fall = r_fall;
  assign o_clk_running = r_running;
  assign o_div_active  = r_div;

endmodule

// File: tb/tb_sd_clock_gen.sv
// Self-checking bench for sd_clock_gen: directed scenarios plus random traffic, every edge
// compared against a model that tracks absolute boundary times rather than a counter.
module tb_sd_clock_gen;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] div = '0;
  logic         sd, rise, fall, running;
  logic [W-1:0] div_act;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 run, 2 hold; next boundary kept as an absolute edge number.
  int           m_mode = 0;
  bit           m_sd = 0, m_rise = 0, m_fall = 0;
  logic [W-1:0] m_div = '0;
  longint       cyc = 0, m_next = 0;

  sd_clock_gen #(.DIV_WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_stop_req   (stop),
    .i_divider    (div),
    .o_sd_clk     (sd),
    .o_sd_clk_rise(rise),
    .o_sd_clk_fall(fall),
    .o_clk_running(running),
    .o_div_active (div_act)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_rise = 0;
    m_fall = 0;
    if (rst) begin
      m_mode = 0;
      m_sd   = 0;
      m_div  = '0;
    end else if (m_mode != 1) begin
      if (en && !stop) begin
        m_mode = 1;
        m_div  = div;
        m_next = cyc + m_div + 1;
      end else if (m_mode == 2 && !en) begin
        m_mode = 0;
      end
    end else if (cyc == m_next) begin
      if (!m_sd) begin
        m_sd   = 1;
        m_rise = 1;
      end else begin
        m_sd   = 0;
        m_fall = 1;
        if (!en) m_mode = 0;
        else if (stop) m_mode = 2;
        else m_div = div;
      end
      m_next = cyc + m_div + 1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check(tag, {20'd0, sd, rise, fall, running, div_act},
          {20'd0, m_sd, m_rise, m_fall, (m_mode == 1), m_div});
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Steps until sd_clk leaves lvl; checks the step count, including the transition edge.
  task automatic phase_len(input string tag, input bit lvl, input int exp);
    int n = 0;
    while (sd === lvl && n < 1000) begin
      step(tag);
      n++;
    end
    check(tag, n, exp);
  endtask

  task automatic wait_level(input string tag, input bit lvl);
    int g = 0;
    while (sd !== lvl && g < 1000) begin
      step(tag);
      g++;
    end
    check({tag, "_reached"}, sd, lvl);
  endtask

  initial begin
    // Reset and divider 0
    rst = 1;
    steps("reset", 2);
    check("reset_outs", {sd, rise, fall, running, div_act}, '0);
    rst = 0; en = 1; div = 0;
    step("d0_entry");
    check("d0_entry_low", {sd, running}, 2'b01);
    step("d0_first_rise");
    check("d0_rise_strobe", {sd, rise, fall}, 3'b110);
    steps("d0_run", 10);

    // Divider 3: latency, phase lengths
    rst = 1; step("rst2"); rst = 0;
    div = 3;
    step("d3_entry");
    phase_len("d3_first_rise", 0, 4);
    phase_len("d3_high", 1, 4);
    phase_len("d3_low", 0, 4);
    check("d3_div_active", div_act, 3);

    // Divider change 3->1 two cycles into a high phase
    steps("d3_mid", 2);
    div = 1;
    phase_len("d31_high_rest", 1, 2);
    check("d31_div_active", div_act, 1);
    phase_len("d31_low", 0, 2);
    phase_len("d31_high", 1, 2);

    // Flow-control stop mid-high with divider 2
    rst = 1; step("rst3"); rst = 0;
    div = 2;
    wait_level("d2_high", 1);
    step("d2_mid");
    stop = 1;
    phase_len("stop_high_rest", 1, 2);
    steps("stop_hold", 6);
    check("stop_parked", {sd, running}, 2'b00);
    stop = 0;
    phase_len("stop_release_low", 0, 4);

    // Enable dropped mid-low with divider 5
    div = 5;
    wait_level("d5_low", 0);
    wait_level("d5_high", 1);
    wait_level("d5_low2", 0);
    step("d5_mid_low");
    en = 0;
    steps("en_drop_low", 20);
    check("en_drop_low_idle", {sd, running}, 2'b00);

    // Enable dropped mid-high together with stop_req: idle wins
    en = 1; div = 2;
    wait_level("es_high", 1);
    en = 0; stop = 1;
    steps("en_stop_high", 8);
    check("en_stop_idle", {sd, running}, 2'b00);
    stop = 0;

    // All-ones divider
    en = 1; div = '1;
    step("dff_entry");
    phase_len("dff_first_rise", 0, 256);
    phase_len("dff_high", 1, 256);

    // Reset while sd_clk is high
    div = 3;
    wait_level("rsth_high", 1);
    step("rsth_mid");
    rst = 1;
    step("rst_high");
    check("rst_high_outs", {sd, rise, fall, running}, 4'b0000);
    rst = 0; en = 0;
    step("rst_high_after");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) en = ~en;
      if ($urandom_range(14) == 0) stop = ~stop;
      if ($urandom_range(9) == 0) div = W'($urandom_range(5));
      rst = ($urandom_range(299) == 0);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
